pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the five-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register.
- Each cycle it produces the per-stage EN/flush pair, the PC source select and trap signalling.
- Inputs it arbitrates between: load-use hazards, taken branches, mret, MEM-stage exceptions and multi-cycle data-memory waits.
- A bounded wait FSM turns a data-memory timeout into a bus-error trap.

Parameters:
MEM_TIMEOUT, 16, MEM_WAIT cycles without dmem_ready before bus error (>=2)
CNT_W, 32, width of stall_cycles counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
rs1_ID, rs2_ID  in  5 each  source registers of ID instruction
use_rs1_ID, use_rs2_ID  in  1 each  ID instruction reads rs1/rs2
rd_EX  in  5  EX destination register
mem_r_EX  in  1  EX instruction is a load
branch_taken_EX  in  1  EX resolved taken branch/jump
mem_r_MEM, WR_MEM  in  1 each  MEM instruction reads/writes data memory
exp_vector_MEM  in  2  MEM exception code, 0 = none
mret_MEM  in  1  MEM instruction is mret
dmem_ready  in  1  data memory completes access this cycle
en_PC  out  1  PC update enable
en_IFID, en_IDEX, en_EXMEM, en_MEMWB  out  1 each  latch enables
flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB  out  1 each  latch flush (effective only with EN=1)
pc_sel  out  2  00 seq, 01 branch, 10 trap vector, 11 mepc
trap_take  out  1  one-cycle pulse, trap redirect taken
trap_cause  out  2  01 MEM exception, 10 bus timeout; held until next trap
bus_err  out  1  one-cycle pulse on timeout
stall_cycles  out  CNT_W  free-running count of stalled cycles, wraps

Behaviour:
- States RUN, MEM_WAIT, TRAP. Counter wait_cnt counts MEM_WAIT cycles.
- Reset (rst=0, any state incl. mid-wait): state RUN, wait_cnt=0, trap_cause=0, stall_cycles=0. Outputs settle to RUN defaults.
- Outputs are combinational from state and inputs. State, counters and trap_cause are registered.
- RUN defaults: all en_*=1, all flush_*=0, pc_sel=00, trap_take=0, bus_err=0.
- RUN priority, highest first:
  1. Exception (exp_vector_MEM!=0): flush all four latches with EN=1, en_PC=0, trap_cause<=01, go to TRAP.
  2. mret_MEM: flush IFID, IDEX, EXMEM; pc_sel=11; MEM/WB advances normally.
  3. Memory stall ((mem_r_MEM|WR_MEM) & !dmem_ready): all en_*=0 and en_PC=0, wait_cnt<=1, go to MEM_WAIT.
  4. Branch (branch_taken_EX): flush IFID and IDEX; pc_sel=01.
  5. Load-use (mem_r_EX & rd_EX!=0 & ((use_rs1_ID & rs1_ID==rd_EX) | (use_rs2_ID & rs2_ID==rd_EX))): en_PC=0, en_IFID=0, flush_IDEX=1; EX/MEM and MEM/WB advance.
- MEM_WAIT:
  - All en_*=0 and en_PC=0 (pipeline frozen).
  - When dmem_ready=1: output exactly as RUN priorities 2, 4, 5 for the held inputs (access done, no exception re-check), wait_cnt<=0, go to RUN.
  - Else if wait_cnt==MEM_TIMEOUT-1: bus_err=1, flush all four latches with EN=1, trap_cause<=10, go to TRAP.
  - Else wait_cnt<=wait_cnt+1.
  - If dmem_ready and the timeout occur in the same cycle, ready wins.
- TRAP (exactly 1 cycle): all en_*=1 with all flush_*=1, en_PC=1, pc_sel=10, trap_take=1, go to RUN.
- stall_cycles increments in any cycle where en_PC=0 and en_IFID=0, i.e. memory stall, MEM_WAIT and load-use; not in TRAP entry. Width CNT_W, wraps modulo 2^CNT_W.
- rd_EX==0 never stalls.
- Simultaneous branch and load-use resolve to the branch: the ID instruction is flushed anyway.
- Latency: every hazard response is visible in the same cycle. The trap redirect appears one cycle after detection.

Test Plan:
- Load x5 in EX, ID reads rs2=x5 with use_rs2=1 -> one cycle en_PC=0, en_IFID=0, flush_IDEX=1; stall_cycles 0->1. Next cycle, with the load moved on, all en=1.
- Load in MEM, dmem_ready low 3 cycles then high -> 3 frozen cycles in MEM_WAIT plus the entry cycle; stall_cycles +4; release cycle all en=1; state back to RUN.
- dmem_ready never asserted, MEM_TIMEOUT=16 -> bus_err pulse on the 16th cycle after entry with all four flushes; next cycle pc_sel=10, trap_take=1, trap_cause=10.
- exp_vector_MEM=2 together with branch_taken_EX=1 -> exception wins: all flushes, en_PC=0. Next cycle pc_sel=10, trap_take=1, trap_cause=01.
- mret_MEM=1 -> flush_IFID/IDEX/EXMEM=1, pc_sel=11, en_MEMWB=1, flush_MEMWB=0.
- rst driven to 0 during MEM_WAIT at wait_cnt=7 -> immediate RUN defaults, stall_cycles=0. After release, a fresh stall starts from wait_cnt=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: per-stage latch enable/flush, PC source select,
// trap redirect and a bounded data-memory wait that turns a timeout into a bus-error trap.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic [4:0]       rd_EX,
  input  logic             mem_r_EX,
  input  logic             branch_taken_EX,
  input  logic             mem_r_MEM,
  input  logic             WR_MEM,
  input  logic [1:0]       exp_vector_MEM,
  input  logic             mret_MEM,
  input  logic             dmem_ready,
  output logic             en_PC,
  output logic             en_IFID,
  output logic             en_IDEX,
  output logic             en_EXMEM,
  output logic             en_MEMWB,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic             flush_EXMEM,
  output logic             flush_MEMWB,
  output logic [1:0]       pc_sel,
  output logic             trap_take,
  output logic [1:0]       trap_cause,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_MEM_WAIT = 2'b01;
  localparam logic [1:0] ST_TRAP     = 2'b10;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_TRAP   = 2'b10;
  localparam logic [1:0] PC_MEPC   = 2'b11;

  localparam logic [1:0] CAUSE_EXC = 2'b01;
  localparam logic [1:0] CAUSE_BUS = 2'b10;

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]        trap_cause_q, trap_cause_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

  logic exc_c;
  logic mem_busy_c;
  logic load_use_c;
  logic wait_last_c;

  // Hazard detection terms shared by RUN and the MEM_WAIT release cycle
  always_comb begin
    exc_c       = (exp_vector_MEM != 2'b00);
    mem_busy_c  = (mem_r_MEM | WR_MEM) & ~dmem_ready;
    load_use_c  = mem_r_EX & (rd_EX != 5'd0) &
                  ((use_rs1_ID & (rs1_ID == rd_EX)) |
                   (use_rs2_ID & (rs2_ID == rd_EX)));
    wait_last_c = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));
  end

  // Next-state and per-cycle pipeline control
  always_comb begin
    en_PC          = 1'b1;
    en_IFID        = 1'b1;
    en_IDEX        = 1'b1;
    en_EXMEM       = 1'b1;
    en_MEMWB       = 1'b1;
    flush_IFID     = 1'b0;
    flush_IDEX     = 1'b0;
    flush_EXMEM    = 1'b0;
    flush_MEMWB    = 1'b0;
    pc_sel         = PC_SEQ;
    trap_take      = 1'b0;
    bus_err        = 1'b0;
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    trap_cause_d   = trap_cause_q;
    stall_cycles_d = stall_cycles_q;

    unique case (state_q)
      ST_RUN: begin
        if (exc_c) begin
          en_PC        = 1'b0;
          flush_IFID   = 1'b1;
          flush_IDEX   = 1'b1;
          flush_EXMEM  = 1'b1;
          flush_MEMWB  = 1'b1;
          trap_cause_d = CAUSE_EXC;
          state_d      = ST_TRAP;
        end else if (mret_MEM) begin
          flush_IFID  = 1'b1;
          flush_IDEX  = 1'b1;
          flush_EXMEM = 1'b1;
          pc_sel      = PC_MEPC;
        end else if (mem_busy_c) begin
          en_PC      = 1'b0;
          en_IFID    = 1'b0;
          en_IDEX    = 1'b0;
          en_EXMEM   = 1'b0;
          en_MEMWB   = 1'b0;
          wait_cnt_d = WAIT_W'(1);
          state_d    = ST_MEM_WAIT;
        end else if (branch_taken_EX) begin
          // A branch also squashes any load-use victim sitting in ID
          flush_IFID = 1'b1;
          flush_IDEX = 1'b1;
          pc_sel     = PC_BRANCH;
        end else if (load_use_c) begin
          en_PC      = 1'b0;
          en_IFID    = 1'b0;
          flush_IDEX = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          // Access completed: resolve the held hazards without re-checking exceptions
          wait_cnt_d = '0;
          state_d    = ST_RUN;
          if (mret_MEM) begin
            flush_IFID  = 1'b1;
            flush_IDEX  = 1'b1;
            flush_EXMEM = 1'b1;
            pc_sel      = PC_MEPC;
          end else if (branch_taken_EX) begin
            flush_IFID = 1'b1;
            flush_IDEX = 1'b1;
            pc_sel     = PC_BRANCH;
          end else if (load_use_c) begin
            en_PC      = 1'b0;
            en_IFID    = 1'b0;
            flush_IDEX = 1'b1;
          end
        end else if (wait_last_c) begin
          en_PC        = 1'b0;
          flush_IFID   = 1'b1;
          flush_IDEX   = 1'b1;
          flush_EXMEM  = 1'b1;
          flush_MEMWB  = 1'b1;
          bus_err      = 1'b1;
          trap_cause_d = CAUSE_BUS;
          wait_cnt_d   = '0;
          state_d      = ST_TRAP;
        end else begin
          en_PC      = 1'b0;
          en_IFID    = 1'b0;
          en_IDEX    = 1'b0;
          en_EXMEM   = 1'b0;
          en_MEMWB   = 1'b0;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      ST_TRAP: begin
        flush_IFID  = 1'b1;
        flush_IDEX  = 1'b1;
        flush_EXMEM = 1'b1;
        flush_MEMWB = 1'b1;
        pc_sel      = PC_TRAP;
        trap_take   = 1'b1;
        state_d     = ST_RUN;
      end

      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase

    // Frozen front end (PC and IF/ID both held) counts as a stalled cycle
    if (!en_PC && !en_IFID) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= '0;
      trap_cause_q   <= 2'b00;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      trap_cause_q   <= trap_cause_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign trap_cause   = trap_cause_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MEM_TIMEOUT = 16;
  localparam int unsigned CNT_W       = 32;

  logic             clk;
  logic             rst;
  logic [4:0]       rs1_ID, rs2_ID, rd_EX;
  logic             use_rs1_ID, use_rs2_ID, mem_r_EX, branch_taken_EX;
  logic             mem_r_MEM, WR_MEM, mret_MEM, dmem_ready;
  logic [1:0]       exp_vector_MEM;
  logic             en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB;
  logic             flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB;
  logic [1:0]       pc_sel, trap_cause;
  logic             trap_take, bus_err;
  logic [CNT_W-1:0] stall_cycles;

  logic [4:0] en_v;
  logic [3:0] fl_v;
  assign en_v = {en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB};
  assign fl_v = {flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB};

  int vec_cnt = 0;
  int err_cnt = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
    .rd_EX(rd_EX), .mem_r_EX(mem_r_EX), .branch_taken_EX(branch_taken_EX),
    .mem_r_MEM(mem_r_MEM), .WR_MEM(WR_MEM), .exp_vector_MEM(exp_vector_MEM),
    .mret_MEM(mret_MEM), .dmem_ready(dmem_ready),
    .en_PC(en_PC), .en_IFID(en_IFID), .en_IDEX(en_IDEX), .en_EXMEM(en_EXMEM), .en_MEMWB(en_MEMWB),
    .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX), .flush_EXMEM(flush_EXMEM),
    .flush_MEMWB(flush_MEMWB), .pc_sel(pc_sel), .trap_take(trap_take),
    .trap_cause(trap_cause), .bus_err(bus_err), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1_ID = 5'd0; rs2_ID = 5'd0; rd_EX = 5'd0;
    use_rs1_ID = 1'b0; use_rs2_ID = 1'b0; mem_r_EX = 1'b0; branch_taken_EX = 1'b0;
    mem_r_MEM = 1'b0; WR_MEM = 1'b0; mret_MEM = 1'b0; dmem_ready = 1'b0;
    exp_vector_MEM = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int early;
    idle_inputs();
    rst = 1'b0;
    #2;
    check("rst_en", 32'(en_v), 32'h1f);
    check("rst_flush", 32'(fl_v), 32'h0);
    check("rst_stall", stall_cycles, 32'd0);
    check("rst_cause", 32'(trap_cause), 32'd0);
    #4 rst = 1'b1;
    tick();

    // Idle pipeline
    #2;
    check("idle_en", 32'(en_v), 32'h1f);
    check("idle_pcsel", 32'(pc_sel), 32'd0);
    tick();

    // Load-use on rs2
    mem_r_EX = 1'b1; rd_EX = 5'd5; use_rs2_ID = 1'b1; rs2_ID = 5'd5;
    #2;
    check("lu_en", 32'(en_v), 32'h07);
    check("lu_flush", 32'(fl_v), 32'h4);
    check("lu_pcsel", 32'(pc_sel), 32'd0);
    check("lu_stall_pre", stall_cycles, 32'd0);
    tick();
    idle_inputs();
    #2;
    check("lu_stall_post", stall_cycles, 32'd1);
    check("lu_after_en", 32'(en_v), 32'h1f);
    tick();

    // Load to x0 never stalls
    mem_r_EX = 1'b1; rd_EX = 5'd0; use_rs1_ID = 1'b1; rs1_ID = 5'd0;
    #2;
    check("x0_en", 32'(en_v), 32'h1f);
    check("x0_flush", 32'(fl_v), 32'h0);
    tick();

    // Branch together with load-use: branch wins
    rd_EX = 5'd7; rs1_ID = 5'd7; branch_taken_EX = 1'b1;
    #2;
    check("brlu_en", 32'(en_v), 32'h1f);
    check("brlu_flush", 32'(fl_v), 32'hc);
    check("brlu_pcsel", 32'(pc_sel), 32'd1);
    tick();
    idle_inputs();
    #2;
    check("brlu_stall", stall_cycles, 32'd1);

    // Memory wait: entry + 3 frozen cycles, then ready
    mem_r_MEM = 1'b1; dmem_ready = 1'b0;
    #2;
    check("mw_entry_en", 32'(en_v), 32'h00);
    tick();
    for (int i = 0; i < 3; i++) begin
      #2;
      check("mw_frozen_en", 32'(en_v), 32'h00);
      check("mw_frozen_flush", 32'(fl_v), 32'h0);
      tick();
    end
    dmem_ready = 1'b1;
    #2;
    check("mw_release_en", 32'(en_v), 32'h1f);
    check("mw_release_buserr", 32'(bus_err), 32'd0);
    check("mw_stall", stall_cycles, 32'd5);
    tick();
    idle_inputs();
    #2;
    check("mw_back_run_en", 32'(en_v), 32'h1f);
    check("mw_stall_after", stall_cycles, 32'd5);
    tick();

    // mret
    mret_MEM = 1'b1;
    #2;
    check("mret_en", 32'(en_v), 32'h1f);
    check("mret_flush", 32'(fl_v), 32'he);
    check("mret_pcsel", 32'(pc_sel), 32'd3);
    tick();
    idle_inputs();

    // Exception beats branch
    exp_vector_MEM = 2'd2; branch_taken_EX = 1'b1;
    #2;
    check("exc_en", 32'(en_v), 32'h0f);
    check("exc_flush", 32'(fl_v), 32'hf);
    check("exc_pcsel", 32'(pc_sel), 32'd0);
    check("exc_take_early", 32'(trap_take), 32'd0);
    tick();
    idle_inputs();
    #2;
    check("exc_trap_pcsel", 32'(pc_sel), 32'd2);
    check("exc_trap_take", 32'(trap_take), 32'd1);
    check("exc_trap_cause", 32'(trap_cause), 32'd1);
    check("exc_trap_en", 32'(en_v), 32'h1f);
    check("exc_trap_flush", 32'(fl_v), 32'hf);
    check("exc_stall", stall_cycles, 32'd5);
    tick();
    #2;
    check("exc_post_take", 32'(trap_take), 32'd0);
    check("exc_cause_held", 32'(trap_cause), 32'd1);

    // Timeout: store never completes
    WR_MEM = 1'b1; dmem_ready = 1'b0;
    #2;
    check("to_entry_en", 32'(en_v), 32'h00);
    tick();
    early = 0;
    for (int i = 1; i < 15; i++) begin
      #2;
      if (bus_err) early++;
      tick();
    end
    check("to_no_early_buserr", 32'(early), 32'd0);
    #2;
    check("to_buserr", 32'(bus_err), 32'd1);
    check("to_flush", 32'(fl_v), 32'hf);
    check("to_en", 32'(en_v), 32'h0f);
    check("to_stall", stall_cycles, 32'd20);
    tick();
    idle_inputs();
    #2;
    check("to_trap_take", 32'(trap_take), 32'd1);
    check("to_trap_pcsel", 32'(pc_sel), 32'd2);
    check("to_trap_cause", 32'(trap_cause), 32'd2);
    check("to_trap_buserr", 32'(bus_err), 32'd0);
    tick();

    // Reset mid-wait at wait_cnt=7
    mem_r_MEM = 1'b1; dmem_ready = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b0;
    mem_r_MEM = 1'b0;
    #2;
    check("rstw_en", 32'(en_v), 32'h1f);
    check("rstw_stall", stall_cycles, 32'd0);
    check("rstw_cause", 32'(trap_cause), 32'd0);
    rst = 1'b1;
    tick();

    // Fresh stall must run the full timeout again
    mem_r_MEM = 1'b1;
    n = 0;
    #2;
    while (!bus_err && n < 40) begin
      tick();
      n++;
      #2;
    end
    check("rstw_timeout_cycles", 32'(n), 32'd15);
    check("rstw_timeout_stall", stall_cycles, 32'd15);
    tick();
    idle_inputs();
    #2;
    check("rstw_trap_cause", 32'(trap_cause), 32'd2);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
